mr_read_ctrl: RTL and testbench



---
 rtl/mr_read_ctrl_pkg.sv | 30 +++
 rtl/mr_align.sv | 31 +++
 rtl/mr_read_ctrl.sv | 155 +++++++++++++++
 tb/tb_mr_read_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mr_read_ctrl_pkg.sv
// mr_read_ctrl_pkg: shared definitions for the MR-stage memory-read controller.
//   - state_t   : controller FSM state encoding
//   - SZ_*      : operand size codes as presented on the size input
//   - needs_split(): whether an operand crosses a 4-byte word boundary
package mr_read_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD0  = 2'd1,
      RD1  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_W = 2'd1;
   localparam logic [1:0] SZ_D = 2'd2;

   // A byte never splits; a halfword splits only from offset 3; a word (or
   // size code 3, treated as a word) splits from any non-zero offset.
   function automatic logic needs_split(input logic [1:0] ofs, input logic [1:0] sz);
      logic res;
      case (sz)
         SZ_B:    res = 1'b0;
         SZ_W:    res = (ofs == 2'd3);
         default: res = (ofs != 2'd0);
      endcase
      return res;
   endfunction

endpackage

// File: rtl/mr_align.sv
// mr_align: combinational right-align and zero-extend of a load operand.
// Ports:
//   hilo [63:0] in  : {high word, low word} as read from memory
//   ofs  [1:0]  in  : byte offset of the operand inside the low word
//   size [1:0]  in  : operand size code (byte / halfword / word, 3 = word)
//   val  [31:0] out : operand shifted down to bit 0, upper bits cleared
module mr_align
   import mr_read_ctrl_pkg::*;
(
   input  logic [63:0] hilo,
   input  logic [1:0]  ofs,
   input  logic [1:0]  size,
   output logic [31:0] val
);

   logic [31:0] shifted_s;

   // Little-endian: the operand's first byte sits at byte lane ofs.
   assign shifted_s = 32'(hilo >> {ofs, 3'b000});

   // Mask the shifted word down to the operand size.
   always_comb begin
      val = 32'h0000_0000;
      case (size)
         SZ_B:    val = {24'h00_0000, shifted_s[7:0]};
         SZ_W:    val = {16'h0000, shifted_s[15:0]};
         default: val = shifted_s;
      endcase
   end

endmodule

// File: rtl/mr_read_ctrl.sv
// mr_read_ctrl: MR-stage memory-read controller. Accepts a load from MR,
// issues one or two word-aligned reads, merges and right-aligns the result.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   mr_v, re           : MR holds a valid instruction that needs a read
//   addr [31:0]        : operand byte address
//   size [1:0]         : operand size code
//   stage_adv          : instruction leaves MR this cycle
//   flush              : kill the instruction in MR
//   mem_req/mem_addr   : word-aligned read request (held until mem_ack)
//   mem_ack/mem_rdata  : request accepted, read data valid this cycle
//   read_finished      : mem_val is valid for the current MR instruction
//   mem_val [31:0]     : zero-extended right-aligned operand
// All outputs are registered.
module mr_read_ctrl
   import mr_read_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        mr_v,
   input  logic        re,
   input  logic [31:0] addr,
   input  logic [1:0]  size,
   input  logic        stage_adv,
   input  logic        flush,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        read_finished,
   output logic [31:0] mem_val
);

   state_t      state_r, next_state_s;
   logic [31:0] a_q;
   logic [1:0]  s_q;
   logic        split_q;
   logic [31:0] lo_q, hi_q;
   logic        kill_q;

   logic        accept_s;
   logic        ack_s;
   logic        killed_s;
   logic [31:0] lo_next_s, hi_next_s;
   logic [31:0] align_s;

   logic        mem_req_r;
   logic [31:0] mem_addr_r;
   logic        read_finished_r;
   logic [31:0] mem_val_r;

   assign accept_s  = (state_r == IDLE) & mr_v & re & ~flush;
   // An ack is only meaningful while a request is actually on the port.
   assign ack_s     = mem_ack & mem_req_r;
   // A flush arriving together with the ack kills the access as well.
   assign killed_s  = kill_q | flush;
   // Data as it will look after this edge, so mem_val can be registered on
   // entry to DONE.
   assign lo_next_s = ((state_r == RD0) && ack_s) ? mem_rdata : lo_q;
   assign hi_next_s = ((state_r == RD1) && ack_s) ? mem_rdata : hi_q;

   mr_align u_align (
      .hilo (({hi_next_s, lo_next_s})),
      .ofs  (a_q[1:0]),
      .size (s_q),
      .val  (align_s)
   );

   // Next-state logic.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) next_state_s = RD0;
            else          next_state_s = IDLE;
         end
         RD0: begin
            if (ack_s) begin
               if (killed_s)     next_state_s = IDLE;
               else if (split_q) next_state_s = RD1;
               else              next_state_s = DONE;
            end else begin
               next_state_s = RD0;
            end
         end
         RD1: begin
            if (ack_s) begin
               if (killed_s) next_state_s = IDLE;
               else          next_state_s = DONE;
            end else begin
               next_state_s = RD1;
            end
         end
         DONE: begin
            if (stage_adv | flush) next_state_s = IDLE;
            else                   next_state_s = DONE;
         end
         default: next_state_s = IDLE;
      endcase
   end

   // State, capture, data and kill registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         a_q     <= 32'h0000_0000;
         s_q     <= 2'd0;
         split_q <= 1'b0;
         lo_q    <= 32'h0000_0000;
         hi_q    <= 32'h0000_0000;
         kill_q  <= 1'b0;
      end else begin
         state_r <= next_state_s;
         if (accept_s) begin
            a_q     <= addr;
            s_q     <= size;
            split_q <= needs_split(addr[1:0], size);
         end
         lo_q   <= lo_next_s;
         hi_q   <= hi_next_s;
         // Remember a flush until the outstanding read drains.
         kill_q <= ((state_r == RD0) || (state_r == RD1)) && killed_s
                   && (next_state_s != IDLE);
      end
   end

   // Registered outputs, derived from the state being entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_req_r       <= 1'b0;
         mem_addr_r      <= 32'h0000_0000;
         read_finished_r <= 1'b0;
         mem_val_r       <= 32'h0000_0000;
      end else begin
         mem_req_r       <= (next_state_s == RD0) || (next_state_s == RD1);
         read_finished_r <= (next_state_s == DONE);
         mem_val_r       <= (next_state_s == DONE) ? align_s : 32'h0000_0000;
         case (next_state_s)
            RD0: begin
               if (state_r == IDLE) mem_addr_r <= {addr[31:2], 2'b00};
               else                 mem_addr_r <= {a_q[31:2], 2'b00};
            end
            // Wraps modulo 2^32 past the top word.
            RD1:     mem_addr_r <= {a_q[31:2], 2'b00} + 32'd4;
            default: mem_addr_r <= 32'h0000_0000;
         endcase
      end
   end

   assign mem_req       = mem_req_r;
   assign mem_addr      = mem_addr_r;
   assign read_finished = read_finished_r;
   assign mem_val       = mem_val_r;

endmodule

// File: tb/tb_mr_read_ctrl.sv
// tb_mr_read_ctrl: directed self-checking bench for mr_read_ctrl.
module tb_mr_read_ctrl;
   import mr_read_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst, mr_v, re, stage_adv, flush, mem_ack;
   logic [31:0] addr, mem_rdata;
   logic [1:0]  size;
   logic        mem_req, read_finished;
   logic [31:0] mem_addr, mem_val;

   int checks = 0;
   int errors = 0;

   mr_read_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .mr_v          (mr_v),
      .re            (re),
      .addr          (addr),
      .size          (size),
      .stage_adv     (stage_adv),
      .flush         (flush),
      .mem_req       (mem_req),
      .mem_addr      (mem_addr),
      .mem_ack       (mem_ack),
      .mem_rdata     (mem_rdata),
      .read_finished (read_finished),
      .mem_val       (mem_val)
   );

   always #5 clk = ~clk;

   // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle_outputs(input string tag);
      check({tag, "_req"}, {31'd0, mem_req}, 32'd0);
      check({tag, "_fin"}, {31'd0, read_finished}, 32'd0);
      check({tag, "_val"}, mem_val, 32'h0);
   endtask

   initial begin
      rst = 1'b1; mr_v = 1'b0; re = 1'b0; addr = 32'h0; size = 2'd0;
      stage_adv = 1'b0; flush = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
      tick(); tick();
      rst = 1'b0;
      idle_outputs("reset");
      check("reset_addr", mem_addr, 32'h0);

      // Aligned dword, ack in first RD0 cycle
      mr_v = 1'b1; re = 1'b1; addr = 32'h0000_1000; size = 2'd2;
      tick();                                        // cycle 1
      check("al_req", {31'd0, mem_req}, 32'd1);
      check("al_addr", mem_addr, 32'h0000_1000);
      check("al_fin1", {31'd0, read_finished}, 32'd0);
      mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      tick();                                        // cycle 2
      mem_ack = 1'b0;
      check("al_fin2", {31'd0, read_finished}, 32'd1);
      check("al_val", mem_val, 32'hDEAD_BEEF);
      check("al_req2", {31'd0, mem_req}, 32'd0);
      // Advance with the next load already presented
      stage_adv = 1'b1; addr = 32'h0000_1002; size = 2'd0;
      tick();                                        // IDLE, samples next load
      stage_adv = 1'b0;
      idle_outputs("adv1");

      // Unaligned byte at 0x1002
      tick();
      check("b_req", {31'd0, mem_req}, 32'd1);
      check("b_addr", mem_addr, 32'h0000_1000);
      mem_ack = 1'b1; mem_rdata = 32'h4433_2211;
      tick();
      mem_ack = 1'b0;
      check("b_fin", {31'd0, read_finished}, 32'd1);
      check("b_val", mem_val, 32'h0000_0033);
      check("b_single", {31'd0, mem_req}, 32'd0);
      stage_adv = 1'b1; size = 2'd1;
      tick();
      stage_adv = 1'b0;

      // Unaligned halfword at 0x1002 (no split)
      tick();
      check("h_addr", mem_addr, 32'h0000_1000);
      mem_ack = 1'b1; mem_rdata = 32'h4433_2211;
      tick();
      mem_ack = 1'b0;
      check("h_val", mem_val, 32'h0000_4433);
      check("h_single", {31'd0, mem_req}, 32'd0);
      stage_adv = 1'b1; addr = 32'h0000_1003; size = 2'd2;
      tick();
      stage_adv = 1'b0;                              // cycle 0 of split load

      // Split dword at 0x1003, each ack delayed two cycles
      tick();                                        // cycle 1
      check("s_addr0", mem_addr, 32'h0000_1000);
      tick();                                        // cycle 2
      check("s_hold0", {31'd0, mem_req}, 32'd1);
      tick();                                        // cycle 3
      check("s_hold0a", mem_addr, 32'h0000_1000);
      mem_ack = 1'b1; mem_rdata = 32'h4433_2211;
      tick();                                        // cycle 4
      mem_ack = 1'b0; mem_rdata = 32'h0;
      check("s_req1", {31'd0, mem_req}, 32'd1);
      check("s_addr1", mem_addr, 32'h0000_1004);
      check("s_fin4", {31'd0, read_finished}, 32'd0);
      tick();                                        // cycle 5
      tick();                                        // cycle 6
      check("s_fin6", {31'd0, read_finished}, 32'd0);
      mem_ack = 1'b1; mem_rdata = 32'h8877_6655;
      tick();                                        // cycle 7
      mem_ack = 1'b0; mem_rdata = 32'h0;
      check("s_fin7", {31'd0, read_finished}, 32'd1);
      check("s_val", mem_val, 32'h7766_5544);

      // Hold in DONE for five cycles
      for (int i = 0; i < 5; i++) begin
         tick();
         check("hold_fin", {31'd0, read_finished}, 32'd1);
         check("hold_val", mem_val, 32'h7766_5544);
      end
      stage_adv = 1'b1; addr = 32'hFFFF_FFFE; size = 2'd2;
      tick();
      stage_adv = 1'b0;
      idle_outputs("adv2");

      // Dword at 0xFFFFFFFE: second read wraps to 0
      tick();
      check("w_addr0", mem_addr, 32'hFFFF_FFFC);
      mem_ack = 1'b1; mem_rdata = 32'hAABB_CCDD;
      tick();
      check("w_addr1", mem_addr, 32'h0000_0000);
      check("w_req1", {31'd0, mem_req}, 32'd1);
      mem_rdata = 32'h1122_3344;
      tick();
      mem_ack = 1'b0;
      check("w_val", mem_val, 32'h3344_AABB);
      stage_adv = 1'b1; addr = 32'hFFFF_FFFF; size = 2'd1;
      tick();
      stage_adv = 1'b0;

      // Halfword at 0xFFFFFFFF: split, wraps
      tick();
      check("wh_addr0", mem_addr, 32'hFFFF_FFFC);
      mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
      tick();
      check("wh_addr1", mem_addr, 32'h0000_0000);
      mem_rdata = 32'h9ABC_DEF0;
      tick();
      mem_ack = 1'b0;
      check("wh_val", mem_val, 32'h0000_F012);
      stage_adv = 1'b1; addr = 32'h0000_1001; size = 2'd2;
      tick();
      stage_adv = 1'b0;

      // Flush in RD0 of a split load, ack three cycles later
      tick();                                        // RD0
      check("f_req", {31'd0, mem_req}, 32'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0; mr_v = 1'b0; re = 1'b0;
      check("f_hold1", {31'd0, mem_req}, 32'd1);
      check("f_haddr", mem_addr, 32'h0000_1000);
      tick();
      check("f_fin", {31'd0, read_finished}, 32'd0);
      tick();
      check("f_hold3", {31'd0, mem_req}, 32'd1);
      mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
      tick();
      mem_ack = 1'b0;
      idle_outputs("f_after");
      tick();
      idle_outputs("f_nord1");

      // Reset while in RD1
      mr_v = 1'b1; re = 1'b1; addr = 32'h0000_2002; size = 2'd2;
      tick();                                        // RD0
      mr_v = 1'b0; re = 1'b0;
      mem_ack = 1'b1; mem_rdata = 32'h0102_0304;
      tick();                                        // RD1
      mem_ack = 1'b0;
      check("r_req", {31'd0, mem_req}, 32'd1);
      check("r_addr", mem_addr, 32'h0000_2004);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      idle_outputs("r_after");
      tick();
      idle_outputs("r_idle");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
